sink_checker: RTL

SINK_CHECKER -- requirements
Module: sink_checker

---
 rtl/sink_checker.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/sink_checker.sv
`default_nettype none
// ============================================================================
// Module      : sink_checker
// Description : NoC traffic sink. Accepts flits under optional periodic
//               backpressure, checks destination, VC, source ID and per-ID
//               sequence ordering, and keeps saturating flit and error
//               counters plus sticky error / done flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sink_checker #(
  parameter int                   WIDTH        = 32,
  parameter int                   N            = 16,
  parameter int                   NUM_VC       = 2,
  parameter logic [$clog2(N)-1:0] NODE         = '0,
  parameter int                   NUM_SRC      = 16,
  parameter int                   STALL_PERIOD = 0,
  parameter int                   NUM_TESTS    = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          data_in,
  input  logic [$clog2(NUM_VC)-1:0] vc_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [31:0]               rx_count,
  output logic [15:0]               err_count,
  output logic                      error,
  output logic                      done
);

  localparam int N_ADDR_WIDTH  = $clog2(N);
  localparam int VC_ADDR_WIDTH = $clog2(NUM_VC);
  localparam int c_cw          = WIDTH - 2*N_ADDR_WIDTH - VC_ADDR_WIDTH - 8;
  localparam int c_id_lsb      = c_cw;
  localparam int c_vc_lsb      = c_cw + 8;
  localparam int c_dest_lsb    = c_cw + 8 + VC_ADDR_WIDTH;

  localparam logic [0:0] c_st_run  = 1'b0;
  localparam logic [0:0] c_st_done = 1'b1;

  // The sequence field needs at least two bits for the modular ordering check
  generate
    if (c_cw < 2) begin : g_bad_width
      $error("sink_checker: WIDTH too small, sequence field must be >= 2 bits");
    end
  endgenerate

  // Decoded flit fields
  logic [c_cw-1:0]          w_seq;
  logic [7:0]               w_id;
  logic [VC_ADDR_WIDTH-1:0] w_vc;
  logic [N_ADDR_WIDTH-1:0]  w_dest;
  logic [N_ADDR_WIDTH-1:0]  w_src;

  assign w_seq  = data_in[c_cw-1:0];
  assign w_id   = data_in[c_id_lsb +: 8];
  assign w_vc   = data_in[c_vc_lsb +: VC_ADDR_WIDTH];
  assign w_dest = data_in[c_dest_lsb +: N_ADDR_WIDTH];
  assign w_src  = data_in[WIDTH-1 -: N_ADDR_WIDTH];

  // Registered state
  logic                r_ready;
  logic [31:0]         r_rx_count;
  logic [15:0]         r_err_count;
  logic                r_error;
  logic [0:0]          r_state;
  logic [0:0]          w_state_next;
  logic [NUM_SRC-1:0]  r_seen;
  logic [c_cw-1:0]     r_last_seq [NUM_SRC];

  // Per-flit check results
  logic                w_accept;
  logic                w_seen_sel;
  logic [c_cw-1:0]     w_last_sel;
  logic [c_cw-1:0]     w_seq_delta;
  logic                w_err_dest;
  logic                w_err_vc;
  logic                w_err_id;
  logic                w_err_seq;
  logic                w_any_err;
  logic [31:0]         w_rx_next;
  logic [15:0]         w_err_next;
  logic                w_done;

  assign w_accept = valid_in && r_ready;

  // Select the sequence-table entry addressed by the flit's source ID
  always_comb begin
    w_seen_sel = 1'b0;
    w_last_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_id == 8'(i)) begin
        w_seen_sel = r_seen[i];
        w_last_sel = r_last_seq[i];
      end
    end
  end

  assign w_err_dest  = (w_dest != NODE);
  assign w_err_vc    = (w_vc != vc_in);
  assign w_err_id    = (int'(w_id) >= NUM_SRC);
  assign w_seq_delta = w_seq - w_last_sel;

  // Sequence check: a zero or "negative" modular step is out of order
  always_comb begin
    w_err_seq = 1'b0;
    if (!w_err_id) begin
      if (!w_seen_sel) begin
        w_err_seq = (w_seq == '0);
      end else begin
        w_err_seq = (w_seq_delta == '0) || w_seq_delta[c_cw-1];
      end
    end
  end

  assign w_any_err  = w_err_dest | w_err_vc | w_err_id | w_err_seq;
  assign w_rx_next  = (r_rx_count == 32'hFFFF_FFFF) ? r_rx_count : r_rx_count + 32'd1;
  assign w_err_next = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;

  // Backpressure generation: either periodic one-cycle stall or always ready
  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int c_sc_w = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      logic [c_sc_w-1:0] r_stall_cnt;
      logic [c_sc_w-1:0] w_stall_next;

      assign w_stall_next = (r_stall_cnt == c_sc_w'(STALL_PERIOD - 1)) ?
                            '0 : r_stall_cnt + c_sc_w'(1);

      // Free-running mod-P counter; ready drops when the counter wraps to 0
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_stall_cnt <= '0;
          r_ready     <= 1'b0;
        end else begin
          r_stall_cnt <= w_stall_next;
          r_ready     <= (w_stall_next != '0);
        end
      end
    end else begin : g_no_stall
      // No stalls: ready rises on the first edge out of reset and stays high
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_ready <= 1'b0;
        end else begin
          r_ready <= 1'b1;
        end
      end
    end
  endgenerate

  // Accepted-flit and failed-flit counters plus sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_count  <= '0;
      r_err_count <= '0;
      r_error     <= 1'b0;
    end else if (w_accept) begin
      r_rx_count <= w_rx_next;
      if (w_any_err) begin
        r_err_count <= w_err_next;
        r_error     <= 1'b1;
      end
    end
  end

  // Per-ID sequence table: only clean-sequence flits with a valid ID update it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seen <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_last_seq[i] <= '0;
      end
    end else if (w_accept && !w_err_id && !w_err_seq) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_id == 8'(i)) begin
          r_seen[i]     <= 1'b1;
          r_last_seq[i] <= w_seq;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: leave RUN as soon as the updated count reaches NUM_TESTS
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_run: begin
        if ((w_accept && (w_rx_next >= 32'(NUM_TESTS))) ||
            (r_rx_count >= 32'(NUM_TESTS))) begin
          w_state_next = c_st_done;
        end
      end
      c_st_done: w_state_next = c_st_done;
      default:   w_state_next = c_st_run;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_done = 1'b0;
    if (r_state == c_st_done) begin
      w_done = 1'b1;
    end
  end

  assign ready_out = r_ready;
  assign rx_count  = r_rx_count;
  assign err_count = r_err_count;
  assign error     = r_error;
  assign done      = w_done;

`ifndef SYNTHESIS
  // Simulation trace of every accepted flit
  always @(posedge clk) begin
    if (rst && w_accept) begin
      $display("sink %0d t=%0t src=%0d id=%0d seq=%0d err(dest,vc,id,seq)=%b%b%b%b",
               NODE, $time, w_src, w_id, w_seq,
               w_err_dest, w_err_vc, w_err_id, w_err_seq);
    end
  end
`endif

endmodule
`default_nettype wire
